// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the shared memory port and the arbiter.
// The err signal is present only when ARB_TIMEOUT_EN is defined.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
`ifdef ARB_TIMEOUT_EN
  logic        err;
`endif

  modport slave (
`ifdef ARB_TIMEOUT_EN
    output err,
`endif
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    output i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
`ifdef ARB_TIMEOUT_EN
    input  err,
`endif
    output i_req, i_addr, d_req, d_addr, d_wdata, d_be, mem_rdata, mem_ready,
    input  i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage.
// Define ARB_TIMEOUT_EN to abort accesses whose mem_ready never arrives.
//
// state | meaning
// IDLE  | no access; arbitrate pending requests
// GNT_I | instruction fetch owns the memory port
// GNT_D | data load/store owns the memory port
// RESP  | done pulse cycle; requesters drop or renew req
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input logic          clk,
  input logic          rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]    state;
  logic [SW-1:0] starveCnt;
  logic          grantD;
  logic          grantI;
  logic          inGnt;
  logic          timedOut;
  logic          memDone;
  logic          unusedBits;

  assign unusedBits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  // Data wins ties until IF has lost STARVE_MAX grants in a row.
  always_comb begin
    grantD = bus.d_req && !(bus.i_req && (starveCnt == STARVE_LIM));
    grantI = bus.i_req && !grantD;
  end

  assign inGnt       = (state == GNT_I) || (state == GNT_D);
  assign bus.mem_en  = inGnt;
  assign bus.busy    = (state != IDLE);
  assign bus.i_stall = bus.i_req & ~bus.i_done;
  assign bus.d_stall = bus.d_req & ~bus.d_done;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] waitCnt;

  assign timedOut = inGnt && !bus.mem_ready && (waitCnt == '0);

  // Down-counter reloads while idle so every grant starts with a full budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= TW'(TIMEOUT);
      bus.err <= 1'b0;
    end else begin
      bus.err <= timedOut;
      if (!inGnt) begin
        waitCnt <= TW'(TIMEOUT);
      end else if (!bus.mem_ready && (waitCnt != '0)) begin
        waitCnt <= waitCnt - 1'b1;
      end
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT != 0);
  assign timedOut      = 1'b0;
`endif

  assign memDone = bus.mem_ready || timedOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starveCnt     <= '0;
      bus.mem_we    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.i_done    <= 1'b0;
      bus.d_done    <= 1'b0;
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grantD) begin
            state         <= GNT_D;
            bus.mem_addr  <= {bus.d_addr[31:2], 2'b00};
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_we    <= bus.d_be;
            if (bus.i_req && (starveCnt != STARVE_LIM)) begin
              starveCnt <= starveCnt + 1'b1;
            end
          end else if (grantI) begin
            state         <= GNT_I;
            bus.mem_addr  <= {bus.i_addr[31:2], 2'b00};
            bus.mem_wdata <= '0;
            bus.mem_we    <= '0;
            starveCnt     <= '0;
          end
        end
        GNT_I: begin
          if (memDone) begin
            state       <= RESP;
            bus.i_done  <= 1'b1;
            bus.i_rdata <= timedOut ? 32'hDEADBEEF : bus.mem_rdata;
          end
        end
        GNT_D: begin
          if (memDone) begin
            state      <= RESP;
            bus.d_done <= 1'b1;
            bus.mem_we <= '0;
            // Stores keep the previous load result.
            if (bus.mem_we == 4'b0000) begin
              bus.d_rdata <= timedOut ? 32'hDEADBEEF : bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected done results,
// a negedge monitor pops and compares them; covers ARB_TIMEOUT_EN when defined.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] rdata;
    int          doneCyc;
    logic        err;
  } expT;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   stallI = 0;
  int   vectors = 0;
  int   miscompares = 0;
  expT  iQ[$];
  expT  dQ[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.i_stall) stallI <= stallI + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input bit isD, input int maxCyc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < maxCyc && !seen; n++) begin
      tick();
      seen = isD ? bus.d_done : bus.i_done;
    end
    chk(isD ? "d_done_seen" : "i_done_seen", 32'(seen), 32'd1);
  endtask

  // Monitor: every done pulse must match the next queued expectation.
  always @(negedge clk) begin : monitor
    expT e;
    if (bus.i_done) begin
      if (iQ.size() == 0) begin
        chk("i_done_unexpected", 32'(bus.i_done), 32'd0);
      end else begin
        e = iQ.pop_front();
        chk("i_rdata", bus.i_rdata, e.rdata);
        chk("i_done_cycle", cyc, e.doneCyc);
      end
    end
    if (bus.d_done) begin
      if (dQ.size() == 0) begin
        chk("d_done_unexpected", 32'(bus.d_done), 32'd0);
      end else begin
        e = dQ.pop_front();
        chk("d_rdata", bus.d_rdata, e.rdata);
        chk("d_done_cycle", cyc, e.doneCyc);
`ifdef ARB_TIMEOUT_EN
        chk("err_with_done", 32'(bus.err), 32'(e.err));
`endif
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    int k;
    int s0;
    rst           = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) tick();
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single IF read, memory always ready.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h20080005;
    s0 = stallI;
    bus.i_addr = 32'h00003004;
    bus.i_req  = 1'b1;
    k = cyc;
    iQ.push_back('{32'h20080005, k + 2, 1'b0});
    tick();
    chk("t1_mem_en", 32'(bus.mem_en), 32'd1);
    chk("t1_mem_addr", bus.mem_addr, 32'h00003004);
    chk("t1_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    waitDone(1'b0, 8);
    bus.i_req = 1'b0;
    tick();
    tick();
    chk("t1_i_stall_cycles", stallI - s0, 32'd2);

    // Starvation: data held continuously, IF pending -> 4 data grants then IF.
    bus.mem_rdata = 32'h5555AAAA;
    bus.d_addr = 32'h00000040;
    bus.d_be   = 4'b0000;
    bus.i_addr = 32'h00000100;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    k = cyc;
    for (int g = 0; g < 4; g++) dQ.push_back('{32'h5555AAAA, k + 2 + 3 * g, 1'b0});
    iQ.push_back('{32'h5555AAAA, k + 14, 1'b0});
    for (int g = 0; g < 4; g++) waitDone(1'b1, 6);
    waitDone(1'b0, 6);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    // Simultaneous requests: data first (starve count back at 0), then IF.
    bus.mem_rdata = 32'h0BADC0DE;
    bus.d_addr = 32'h00000010;
    bus.i_addr = 32'h00000200;
    s0 = stallI;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    k = cyc;
    dQ.push_back('{32'h0BADC0DE, k + 2, 1'b0});
    iQ.push_back('{32'hCAFEF00D, k + 5, 1'b0});
    tick();
    chk("t2_mem_addr", bus.mem_addr, 32'h00000010);
    chk("t2_d_stall", 32'(bus.d_stall), 32'd1);
    waitDone(1'b1, 6);
    bus.d_req = 1'b0;
    bus.mem_rdata = 32'hCAFEF00D;
    waitDone(1'b0, 6);
    bus.i_req = 1'b0;
    tick();
    tick();
    chk("t2_i_stall_cycles", stallI - s0, 32'd5);

    // Store with a 3-cycle memory delay; request inputs change after grant.
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h99999999;
    bus.d_addr  = 32'h00000022;
    bus.d_wdata = 32'hAABBCCDD;
    bus.d_be    = 4'b0011;
    bus.d_req   = 1'b1;
    k = cyc;
    dQ.push_back('{32'h0BADC0DE, k + 4, 1'b0});
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("t4_mem_en", 32'(bus.mem_en), 32'd1);
      chk("t4_mem_we", 32'(bus.mem_we), 32'h3);
      chk("t4_mem_addr", bus.mem_addr, 32'h00000020);
      chk("t4_mem_wdata", bus.mem_wdata, 32'hAABBCCDD);
      if (h == 0) begin
        bus.d_addr  = 32'h0000FFF0;
        bus.d_wdata = 32'h0;
        bus.d_be    = 4'hF;
      end
      if (h == 2) bus.mem_ready = 1'b1;
    end
    waitDone(1'b1, 4);
    bus.d_req = 1'b0;
    chk("t4_resp_mem_en", 32'(bus.mem_en), 32'd0);
    chk("t4_resp_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    chk("t4_idle_busy", 32'(bus.busy), 32'd0);
    chk("i_rdata_hold", bus.i_rdata, 32'hCAFEF00D);

    // Reset in the middle of a data grant aborts it with no done pulse.
    bus.mem_ready = 1'b0;
    bus.d_be   = 4'b0000;
    bus.d_addr = 32'h00000080;
    bus.d_req  = 1'b1;
    tick();
    tick();
    chk("t5_gnt_mem_en", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.d_req = 1'b0;
    chk("t5_mem_en", 32'(bus.mem_en), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_d_rdata", bus.d_rdata, 32'd0);
    chk("t5_i_rdata", bus.i_rdata, 32'd0);
    bus.mem_ready = 1'b1;
    repeat (4) tick();
    chk("t5_no_d_done", 32'(bus.d_done), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Stuck memory on a load: done and err 9 cycles after the grant.
    bus.mem_ready = 1'b0;
    bus.d_addr = 32'h00000044;
    bus.d_be   = 4'b0000;
    bus.d_req  = 1'b1;
    k = cyc;
    dQ.push_back('{32'hDEADBEEF, k + 10, 1'b1});
    tick();
    chk("t6_err_idle", 32'(bus.err), 32'd0);
    waitDone(1'b1, 14);
    bus.d_req = 1'b0;
    tick();
    chk("t6_err_pulse_end", 32'(bus.err), 32'd0);
`endif

    repeat (3) tick();
    chk("i_queue_drained", iQ.size(), 32'd0);
    chk("d_queue_drained", dQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
